// File: rtl/apb_sram_pkg.sv
// apb_sram_pkg -- shared types and constants for apb_sram_ctrl.
//   state_e   : 2-bit FSM state encoding of the APB-to-SRAM bridge
//   STRB_BITS : number of byte lanes in a 32-bit APB word
package apb_sram_pkg;

    localparam int STRB_BITS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        W_ACC  = 2'b01,
        R_ADDR = 2'b10,
        R_DATA = 2'b11
    } state_e;

endpackage

// File: rtl/apb_sram_ctrl.sv
// apb_sram_ctrl -- APB slave bridging to a single-port, byte-write SRAM
// with one cycle of read latency.  Writes finish with no wait state,
// reads with exactly one.
//
// Optional feature: define APB_SRAM_PSLVERR_EN to flag addresses outside
// the memory with pslverr (and suppress the memory access).  Without it,
// upper address bits are ignored and addresses alias.
//
// Ports
//   clk, rstn          : clock (rising edge), synchronous active-low reset
//   psel, penable,
//   pwrite, paddr,
//   pwdata, pstrb      : APB request (paddr is a byte address)
//   pready, prdata,
//   pslverr            : APB response
//   mem_en, mem_we,
//   mem_wbe, mem_addr,
//   mem_din            : SRAM request (word address, byte write enables)
//   mem_dout           : SRAM read data, valid the cycle after a read enable
module apb_sram_ctrl
    import apb_sram_pkg::*;
#(
    parameter int ADDR_BITS   = 7,
    parameter int ADDR_AMOUNT = 128,
    parameter int DATA_BITS   = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [31:0]          paddr,
    input  logic [DATA_BITS-1:0] pwdata,
    input  logic [STRB_BITS-1:0] pstrb,
    output logic                 pready,
    output logic [DATA_BITS-1:0] prdata,
    output logic                 pslverr,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [STRB_BITS-1:0] mem_wbe,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_din,
    input  logic [DATA_BITS-1:0] mem_dout
);

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0]   mem_din_q, mem_din_d;
    logic [STRB_BITS-1:0]   mem_wbe_q, mem_wbe_d;
    logic                   setup;
    logic                   xfer_err;
    logic                   unused_paddr;

`ifdef APB_SRAM_PSLVERR_EN
    logic err_q, err_d;
    logic range_err;

    // Out of range if any byte-address bit above the memory is set, or the
    // word index reaches past the populated depth.
    assign range_err = (paddr[31:ADDR_BITS+2] != '0) ||
                       (32'(paddr[ADDR_BITS+1:2]) >= 32'(ADDR_AMOUNT));
    assign xfer_err     = err_q;
    assign unused_paddr = ^paddr[1:0];
`else
    assign xfer_err     = 1'b0;
    // Byte offset and upper bits play no part: accesses are word-aligned
    // and upper addresses alias onto the memory.
    assign unused_paddr = ^{paddr[31:ADDR_BITS+2], paddr[1:0]};
`endif

    assign setup = (state_q == IDLE) && psel && !penable;

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_wbe_d  = mem_wbe_q;
`ifdef APB_SRAM_PSLVERR_EN
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (setup) begin
                    mem_addr_d = paddr[ADDR_BITS+1:2];
                    mem_din_d  = pwdata;
                    mem_wbe_d  = pwrite ? pstrb : '0;
`ifdef APB_SRAM_PSLVERR_EN
                    err_d      = range_err;
`endif
                    state_d    = pwrite ? W_ACC : R_ADDR;
                end
            end
            // Write completes this cycle; an abort also lands in IDLE.
            W_ACC:   state_d = IDLE;
            // Dropping psel during the address cycle abandons the read
            // before any pready is produced.
            R_ADDR:  state_d = psel ? R_DATA : IDLE;
            R_DATA:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_wbe_q  <= '0;
`ifdef APB_SRAM_PSLVERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_wbe_q  <= mem_wbe_d;
`ifdef APB_SRAM_PSLVERR_EN
            err_q      <= err_d;
`endif
        end
    end

    // Handshake and memory strobes come from registered state only, so no
    // APB input reaches pready/mem_en/mem_we combinationally.
    assign pready   = (state_q == W_ACC) || (state_q == R_DATA);
    assign mem_en   = ((state_q == W_ACC) || (state_q == R_ADDR)) && !xfer_err;
    assign mem_we   = (state_q == W_ACC) && !xfer_err;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_wbe  = mem_wbe_q;
    assign prdata   = ((state_q == R_DATA) && !xfer_err) ? mem_dout : '0;
    assign pslverr  = pready && xfer_err;

endmodule

// File: tb/tb_apb_sram_ctrl.sv
module tb_apb_sram_ctrl;

    localparam int AB = 7;
    localparam int AN = 128;

    logic        clk = 1'b0;
    logic        rstn;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_wbe;
    logic [AB-1:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    always #5 clk = ~clk;

    apb_sram_ctrl #(.ADDR_BITS(AB), .ADDR_AMOUNT(AN), .DATA_BITS(32)) dut (
        .clk(clk), .rstn(rstn),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wbe(mem_wbe),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // SRAM behavioural model: byte-write, one cycle read latency.
    logic [31:0] sram   [AN];
    logic [31:0] shadow [AN];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wbe[b]) sram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
            end else begin
                mem_dout <= sram[mem_addr];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int en_cnt   = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_en) en_cnt <= en_cnt + 1;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [6:0]  word;
        logic [31:0] data;
        logic [3:0]  wbe;
        bit          err;
    } exp_t;

    exp_t sbq[$];

    function automatic bit out_of_range(input logic [31:0] a);
`ifdef APB_SRAM_PSLVERR_EN
        return (a[31:AB+2] != 0) || (int'(a[AB+1:2]) >= AN);
`else
        return (a[31] == 1'b1) && 1'b0;
`endif
    endfunction

    // Response monitor: every pready must match the oldest outstanding request.
    always @(negedge clk) begin
        if (pready) begin
            if (sbq.size() == 0) begin
                chk_eq("spurious_pready", 32'(pready), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk_eq("pslverr", 32'(pslverr), 32'(e.err));
                if (e.wr) begin
                    chk_eq("wr_mem_en",   32'(mem_en),   32'(!e.err));
                    chk_eq("wr_mem_we",   32'(mem_we),   32'(!e.err));
                    chk_eq("wr_mem_addr", 32'(mem_addr), 32'(e.word));
                    chk_eq("wr_mem_wbe",  32'(mem_wbe),  32'(e.wbe));
                    chk_eq("wr_mem_din",  mem_din,       e.data);
                    chk_eq("wr_prdata",   prdata,        32'd0);
                end else begin
                    chk_eq("rd_prdata",   prdata,        e.data);
                    chk_eq("rd_mem_en",   32'(mem_en),   32'd0);
                end
            end
        end
    end

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        bit err;
        int w;
        err = out_of_range(a);
        w   = int'(a[AB+1:2]);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
        e.wr = 1'b1; e.word = a[AB+1:2]; e.data = d; e.wbe = s; e.err = err;
        sbq.push_back(e);
        if (!err)
            for (int b = 0; b < 4; b++)
                if (s[b]) shadow[w][8*b +: 8] = d[8*b +: 8];
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a);
        exp_t e;
        bit err;
        err = out_of_range(a);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        e.wr = 1'b0; e.word = a[AB+1:2]; e.wbe = 4'h0; e.err = err;
        e.data = err ? 32'd0 : shadow[int'(a[AB+1:2])];
        sbq.push_back(e);
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk_eq("rd_wait_pready", 32'(pready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_pready"},   32'(pready),   32'd0);
        chk_eq({tag, "_prdata"},   prdata,        32'd0);
        chk_eq({tag, "_pslverr"},  32'(pslverr),  32'd0);
        chk_eq({tag, "_mem_en"},   32'(mem_en),   32'd0);
        chk_eq({tag, "_mem_we"},   32'(mem_we),   32'd0);
        chk_eq({tag, "_mem_wbe"},  32'(mem_wbe),  32'd0);
        chk_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk_eq({tag, "_mem_din"},  mem_din,       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, en0;
        for (int i = 0; i < AN; i++) begin
            sram[i]   = 32'd0;
            shadow[i] = 32'd0;
        end
        mem_dout = 32'd0;
        rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0; pstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        // Full write then a byte-lane write to the same word, read back.
        apb_write(32'h10, 32'hA5A5_1234, 4'hF);
        apb_write(32'h10, 32'hFFFF_FFFF, 4'b0010);
        apb_read (32'h10);
        chk_eq("partial_shadow", shadow[4], 32'hA5A5_FF34);

        // Zero-strobe write must leave the word untouched.
        apb_write(32'h10, 32'h1234_5678, 4'h0);
        apb_read (32'h10);

        // Boundary words.
        apb_write(32'h0,   32'hCAFE_F00D, 4'hF);
        apb_write(32'h1FC, 32'h7777_8888, 4'hF);
        apb_read (32'h1FC);

        // Back-to-back: 3 writes + 2 reads with no idle cycles.
        c0 = cyc;
        apb_write(32'h20, 32'h1111_1111, 4'hF);
        apb_write(32'h24, 32'h2222_2222, 4'hF);
        apb_write(32'h28, 32'h3333_3333, 4'b1001);
        apb_read (32'h24);
        apb_read (32'h28);
        chk_eq("b2b_cycles", 32'(cyc - c0), 32'd12);

        // Abort: psel dropped in the read address cycle.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h20;
        @(posedge clk); #1;
        psel = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_eq("abort_mem_en", 32'(mem_en), 32'd0);
        chk_eq("abort_pready", 32'(pready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_eq("abort_pready2", 32'(pready), 32'd0);
        @(posedge clk); #1;

        // Reset asserted while in the read address cycle.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h28;
        @(posedge clk); #1;
        penable = 1'b1;
        rstn = 1'b0;
        @(posedge clk); #1;
        en0 = en_cnt;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        @(posedge clk); #1;
        @(negedge clk);
        chk_eq("midrst_no_en", 32'(en_cnt - en0), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        apb_read(32'h24);

        // Range handling.
        en0 = en_cnt;
        apb_read(32'h200);
`ifdef APB_SRAM_PSLVERR_EN
        chk_eq("range_rd_no_en", 32'(en_cnt - en0), 32'd0);
        en0 = en_cnt;
        apb_write(32'h204, 32'hDEAD_BEEF, 4'hF);
        chk_eq("range_wr_no_en", 32'(en_cnt - en0), 32'd0);
        apb_read(32'h4);
`else
        chk_eq("alias_rd_en", 32'(en_cnt - en0), 32'd1);
`endif

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_eq("sb_drained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
